// File: rtl/countdown_timer.sv
// countdown_timer
//   Counts down from a preset number of seconds to 0:000 at 1 ms resolution.
//   It uses the same ms/second output format as the up-counting stopwatch, so it
//   can drive the same seven-segment decoder chain.
//
// Ports
//   clk             system clock; all logic is on the rising edge
//   rst_a_n         asynchronous active-low reset; clears outputs, synchronisers and prescaler
//   start           asynchronous level input; a rising edge is a start/restart command
//   pause           asynchronous level input; a rising edge is a pause/resume command
//   preset_s[5:0]   preset seconds; sampled only in IDLE and clamped to MAX_S
//   ms_counter[9:0] remaining milliseconds, 0..999
//   second_counter  remaining seconds, 0..MAX_S
//   running         high while the timer is counting (RUN)
//   done            high while the timer has expired (DONE)
//   done_pulse      high for one cycle on entry to DONE
module countdown_timer #(
  parameter int unsigned CYCLES_PER_MS = 50000,
  parameter int unsigned MAX_S         = 59
) (
  input  logic       clk,
  input  logic       rst_a_n,
  input  logic       start,
  input  logic       pause,
  input  logic [5:0] preset_s,
  output logic [9:0] ms_counter,
  output logic [5:0] second_counter,
  output logic       running,
  output logic       done,
  output logic       done_pulse
);

  localparam int unsigned PW       = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CYCLES_PER_MS - 1);
  localparam logic [5:0]  MAX_S_W  = 6'(MAX_S);
  localparam logic [9:0]  MS_LAST  = 10'd999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [9:0]    ms_q, ms_d;
  logic [5:0]    s_q, s_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          done_pulse_q, done_pulse_d;

  logic [1:0]    start_sync_q;
  logic [1:0]    pause_sync_q;
  logic          start_prev_q;
  logic          pause_prev_q;

  logic          start_evt;
  logic          pause_evt;
  logic          tick;
  logic [5:0]    preset_clamped;
  logic          last_ms;

  // Two-flop synchronisers followed by a delay stage for edge detection
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      start_sync_q <= 2'b00;
      pause_sync_q <= 2'b00;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[0], start};
      pause_sync_q <= {pause_sync_q[0], pause};
      start_prev_q <= start_sync_q[1];
      pause_prev_q <= pause_sync_q[1];
    end
  end

  assign start_evt = start_sync_q[1] & ~start_prev_q;
  assign pause_evt = pause_sync_q[1] & ~pause_prev_q;

  // One-millisecond tick; the prescaler only advances while counting
  assign tick = (state_q == ST_RUN) && (pre_q == PRE_LAST);

  assign preset_clamped = (preset_s > MAX_S_W) ? MAX_S_W : preset_s;

  // True when the pending decrement lands on 0:000 (seconds already 0, one ms left)
  assign last_ms = (s_q == 6'd0) && (ms_q <= 10'd1);

  // State register, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q      <= ST_IDLE;
      pre_q        <= '0;
      ms_q         <= 10'd0;
      s_q          <= 6'd0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      ms_q         <= ms_d;
      s_q          <= s_d;
      running_q    <= running_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    ms_d    = ms_q;
    s_d     = s_q;

    unique case (state_q)
      ST_IDLE: begin
        // Keeping the prescaler at zero here also clears it on IDLE->RUN
        pre_d = '0;
        if (start_evt) begin
          // The decision uses the value already loaded into the counters
          if ((s_q == 6'd0) && (ms_q == 10'd0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          s_d  = preset_clamped;
          ms_d = 10'd0;
        end
      end

      ST_RUN: begin
        pre_d = tick ? '0 : (pre_q + PW'(1));
        if (tick) begin
          if (ms_q != 10'd0) begin
            ms_d = ms_q - 10'd1;
          end else if (s_q != 6'd0) begin
            s_d  = s_q - 6'd1;
            ms_d = MS_LAST;
          end
        end
        // Reaching 0:000 takes priority over a coincident pause
        if (tick && last_ms) begin
          state_d = ST_DONE;
          ms_d    = 10'd0;
          s_d     = 6'd0;
        end else if (pause_evt) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        // Prescaler held so the fractional millisecond survives the pause
        if (pause_evt) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        ms_d = 10'd0;
        s_d  = 6'd0;
        if (start_evt) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    running_d    = (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
    done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  assign ms_counter     = ms_q;
  assign second_counter = s_q;
  assign running        = running_q;
  assign done           = done_q;
  assign done_pulse     = done_pulse_q;

  // Range and consistency properties
  a_ms_range: assert property (@(posedge clk) disable iff (!rst_a_n)
    ms_q <= MS_LAST);
  a_s_range: assert property (@(posedge clk) disable iff (!rst_a_n)
    s_q <= MAX_S_W);
  a_no_zero_run: assert property (@(posedge clk) disable iff (!rst_a_n)
    running_q |-> !((s_q == 6'd0) && (ms_q == 10'd0)));
  a_pulse_in_done: assert property (@(posedge clk) disable iff (!rst_a_n)
    done_pulse_q |-> done_q);
  a_excl: assert property (@(posedge clk) disable iff (!rst_a_n)
    !(running_q && done_q));

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with CYCLES_PER_MS = 4, MAX_S = 59.
module tb_countdown_timer;

  localparam int unsigned CPM  = 4;
  localparam int unsigned MAXS = 59;

  logic       clk;
  logic       rst_a_n;
  logic       start;
  logic       pause;
  logic [5:0] preset_s;
  logic [9:0] ms_counter;
  logic [5:0] second_counter;
  logic       running;
  logic       done;
  logic       done_pulse;

  int checks = 0;
  int errors = 0;
  int run_cycles = 0;
  int pulse_cnt = 0;

  countdown_timer #(
    .CYCLES_PER_MS (CPM),
    .MAX_S         (MAXS)
  ) dut (
    .clk            (clk),
    .rst_a_n        (rst_a_n),
    .start          (start),
    .pause          (pause),
    .preset_s       (preset_s),
    .ms_counter     (ms_counter),
    .second_counter (second_counter),
    .running        (running),
    .done           (done),
    .done_pulse     (done_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count clock edges processed in RUN and cycles with done_pulse high
  always @(posedge clk) begin
    if (running) run_cycles <= run_cycles + 1;
    if (done_pulse) pulse_cnt <= pulse_cnt + 1;
  end

  typedef struct {
    logic [5:0] preset;
    int         exp_s;
  } idle_vec_t;

  idle_vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done) break;
      step(1);
    end
    chk(name, int'(done), 1);
  endtask

  // Pulse start from DONE: IDLE after 3 edges, preset visible one edge later
  task automatic restart(input logic [5:0] p, input int exp_s);
    preset_s = p;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    chk("restart_done", int'(done), 0);
    chk("restart_running", int'(running), 0);
    chk("restart_s_before_load", int'(second_counter), 0);
    step(1);
    chk("restart_reload_s", int'(second_counter), exp_s);
    chk("restart_reload_ms", int'(ms_counter), 0);
  endtask

  initial begin
    int rb;
    int pb;
    int ok;
    int found;

    vecs[0] = '{preset: 6'd63, exp_s: 59};
    vecs[1] = '{preset: 6'd60, exp_s: 59};
    vecs[2] = '{preset: 6'd59, exp_s: 59};
    vecs[3] = '{preset: 6'd58, exp_s: 58};
    vecs[4] = '{preset: 6'd0,  exp_s: 0};
    vecs[5] = '{preset: 6'd1,  exp_s: 1};
    vecs[6] = '{preset: 6'd37, exp_s: 37};
    vecs[7] = '{preset: 6'd2,  exp_s: 2};

    start    = 1'b0;
    pause    = 1'b0;
    preset_s = 6'd5;
    rst_a_n  = 1'b0;

    // Reset holds everything at zero even though a preset is present
    step(3);
    chk("rst_s", int'(second_counter), 0);
    chk("rst_ms", int'(ms_counter), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pulse", int'(done_pulse), 0);
    rst_a_n = 1'b1;

    // Idle load with clamping
    for (int i = 0; i < 8; i++) begin
      preset_s = vecs[i].preset;
      step(1);
      chk($sformatf("idle_s[%0d]", i), int'(second_counter), vecs[i].exp_s);
      chk($sformatf("idle_ms[%0d]", i), int'(ms_counter), 0);
      chk($sformatf("idle_running[%0d]", i), int'(running), 0);
      chk($sformatf("idle_done[%0d]", i), int'(done), 0);
    end

    // Full run from 2:000
    rb = run_cycles;
    pb = pulse_cnt;
    start = 1'b1;
    step(1);
    chk("run_lat1", int'(running), 0);
    start = 1'b0;
    step(1);
    chk("run_lat2", int'(running), 0);
    step(1);
    chk("run_lat3", int'(running), 1);
    chk("run_start_s", int'(second_counter), 2);
    step(3);
    chk("run_pre_tick_ms", int'(ms_counter), 0);
    step(1);
    chk("run_first_s", int'(second_counter), 1);
    chk("run_first_ms", int'(ms_counter), 999);
    step(7995);
    chk("run_last_ms", int'(ms_counter), 1);
    chk("run_last_s", int'(second_counter), 0);
    chk("run_last_running", int'(running), 1);
    chk("run_last_done", int'(done), 0);
    step(1);
    chk("run_end_ms", int'(ms_counter), 0);
    chk("run_end_done", int'(done), 1);
    chk("run_end_pulse", int'(done_pulse), 1);
    chk("run_end_running", int'(running), 0);
    step(1);
    chk("run_end_pulse_gone", int'(done_pulse), 0);
    chk("run_end_done_held", int'(done), 1);
    chk("run_cycles", run_cycles - rb, 8000);
    chk("run_pulse_count", pulse_cnt - pb, 1);

    // Pause at 1:500 for 100 cycles, then resume
    restart(6'd2, 2);
    rb = run_cycles;
    pb = pulse_cnt;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    step(2000);
    chk("pause_at_s", int'(second_counter), 1);
    chk("pause_at_ms", int'(ms_counter), 500);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    step(2);
    chk("pause_running", int'(running), 0);
    ok = 1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (second_counter != 6'd1 || ms_counter != 10'd500 || running || done) ok = 0;
    end
    chk("pause_frozen", ok, 1);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    step(2);
    chk("resume_running", int'(running), 1);
    chk("resume_ms", int'(ms_counter), 500);
    step(1);
    chk("resume_first_tick", int'(ms_counter), 499);
    wait_done("pause_wait_done", 10000);
    chk("pause_done_pulse", int'(done_pulse), 1);
    chk("pause_run_cycles", run_cycles - rb, 8000);
    step(1);
    chk("pause_pulse_count", pulse_cnt - pb, 1);

    // Zero preset goes straight to DONE
    restart(6'd0, 0);
    rb = run_cycles;
    pb = pulse_cnt;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    chk("zero_done", int'(done), 1);
    chk("zero_pulse", int'(done_pulse), 1);
    chk("zero_running", int'(running), 0);
    step(1);
    chk("zero_pulse_gone", int'(done_pulse), 0);
    chk("zero_run_cycles", run_cycles - rb, 0);
    chk("zero_pulse_count", pulse_cnt - pb, 1);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    step(3);
    chk("done_ignores_pause", int'(done), 1);

    // Pause arriving on the final tick is dropped
    restart(6'd1, 1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    found = 0;
    for (int i = 0; i < 5000; i++) begin
      if (second_counter == 6'd0 && ms_counter == 10'd1) begin
        found = 1;
        break;
      end
      step(1);
    end
    chk("final_reach_0_001", found, 1);
    step(1);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    step(1);
    chk("final_pre_running", int'(running), 1);
    chk("final_pre_ms", int'(ms_counter), 1);
    step(1);
    chk("final_done", int'(done), 1);
    chk("final_running", int'(running), 0);
    chk("final_pulse", int'(done_pulse), 1);
    step(10);
    chk("final_still_done", int'(done), 1);
    chk("final_not_running", int'(running), 0);

    // start+pause together: IDLE -> RUN, then RUN -> PAUSE
    restart(6'd2, 2);
    start = 1'b1;
    pause = 1'b1;
    step(1);
    start = 1'b0;
    pause = 1'b0;
    step(2);
    chk("coll_idle_running", int'(running), 1);
    chk("coll_idle_done", int'(done), 0);
    step(5);
    start = 1'b1;
    pause = 1'b1;
    step(1);
    start = 1'b0;
    pause = 1'b0;
    step(2);
    chk("coll_run_running", int'(running), 0);
    chk("coll_run_done", int'(done), 0);
    step(20);
    chk("coll_run_frozen_s", int'(second_counter), 1);
    chk("coll_run_frozen_ms", int'(ms_counter), 998);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    step(2);
    chk("coll_resume_running", int'(running), 1);
    step(10);

    // Asynchronous reset mid-RUN acts before the next clock edge
    #2;
    rst_a_n = 1'b0;
    #1;
    chk("async_rst_s", int'(second_counter), 0);
    chk("async_rst_ms", int'(ms_counter), 0);
    chk("async_rst_running", int'(running), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_pulse", int'(done_pulse), 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    step(1);
    chk("post_rst_s", int'(second_counter), 2);
    chk("post_rst_running", int'(running), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
